// File: rtl/bcd_seg_scanner_pkg.sv
// Shared constants for the BCD 7-segment display blocks.
// Glyphs are active-high {g,f,e,d,c,b,a}.
package bcd_seg_scanner_pkg;

    localparam int DIGITS = 4;
    localparam int IDX_W  = 2;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    function automatic logic [DIGITS-1:0] digit_onehot(
        input logic [IDX_W-1:0] idx
    );
        logic [DIGITS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/bcd_seg_scanner_if.sv
// Count-bus input and display-pin output bundle for the scanner.
// master = counter/board side, slave = scanner.
interface bcd_seg_scanner_if;
    import bcd_seg_scanner_pkg::*;

    logic [4*DIGITS-1:0] bcd;
    logic                load;
    logic                blank_lz;
    logic [DIGITS-1:0]   dp_mask;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic                dp;
    logic                err;

    modport master (
        output bcd, load, blank_lz, dp_mask,
        input  an, seg, dp, err
    );

    modport slave (
        input  bcd, load, blank_lz, dp_mask,
        output an, seg, dp, err
    );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-high 7-segment glyph.
// Non-decimal nibbles show a dash and drop valid_o.
module bcd_to_seg7
    import bcd_seg_scanner_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o,
    output logic       valid_o
);

    always_comb begin
        seg_o   = SEG_DASH;
        valid_o = 1'b1;
        case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Snapshots a packed-BCD count and scans it onto a 4-digit
// multiplexed 7-segment display with dead time and LZ blanking.
module bcd_seg_scanner
    import bcd_seg_scanner_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int DIV_WIDTH  = 16,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    bcd_seg_scanner_if.slave bus
);

    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(SCAN_DIV - 1);
    localparam logic                 POL      = ACTIVE_LOW;
    localparam logic [DIGITS-1:0]    OFF_AN   = {DIGITS{POL}};
    localparam logic [6:0]           OFF_SEG  = {7{POL}};

    logic [4*DIGITS-1:0]  snap_q, snap_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0]    an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic                 err_q, err_d;

    logic [6:0]        glyph [DIGITS];
    logic [DIGITS-1:0] valid;
    logic [DIGITS-1:0] nz;
    logic [DIGITS-1:0] lz;
    logic              wrap;
    logic              zacc;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        bcd_to_seg7 u_dec (
            .nibble_i (snap_q[4*g +: 4]),
            .seg_o    (glyph[g]),
            .valid_o  (valid[g])
        );
        assign nz[g] = |snap_q[4*g +: 4];
    end

    // lz[i]: digit i and everything above it is zero
    always_comb begin
        lz   = '0;
        zacc = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zacc  = zacc & ~nz[i];
            lz[i] = zacc;
        end
    end

    assign wrap = (div_q == DIV_LAST);

    always_comb begin
        snap_d = snap_q;
        div_d  = div_q + DIV_WIDTH'(1);
        idx_d  = idx_q;
        an_d   = OFF_AN;
        seg_d  = OFF_SEG;
        dp_d   = POL;
        err_d  = ~&valid;
        if (bus.load) begin
            snap_d = bus.bcd;
        end
        if (wrap) begin
            div_d = '0;
            idx_d = idx_q + IDX_W'(1);
        end else begin
            an_d = digit_onehot(idx_q) ^ OFF_AN;
            if (bus.blank_lz && lz[idx_q]) begin
                seg_d = SEG_OFF ^ OFF_SEG;
            end else begin
                seg_d = glyph[idx_q] ^ OFF_SEG;
            end
            dp_d = bus.dp_mask[idx_q] ^ POL;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snap_q <= '0;
            div_q  <= '0;
            idx_q  <= '0;
            an_q   <= OFF_AN;
            seg_q  <= OFF_SEG;
            dp_q   <= POL;
            err_q  <= 1'b0;
        end else begin
            snap_q <= snap_d;
            div_q  <= div_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            err_q  <= err_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
    assign bus.err = err_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Bench for bcd_seg_scanner: active-low and active-high copies
// driven in lockstep and compared against a cycle-count model.
module tb_bcd_seg_scanner;
    import bcd_seg_scanner_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd = '0;
    logic        load = 1'b0;
    logic        blz = 1'b0;
    logic [3:0]  dpm = '0;

    int          checks = 0;
    int          errors = 0;
    int          k = 0;
    logic [15:0] snap_m = '0;
    logic [6:0]  gl [10];

    always #5 clk = ~clk;

    bcd_seg_scanner_if if_lo ();
    bcd_seg_scanner_if if_hi ();

    assign if_lo.bcd      = bcd;
    assign if_lo.load     = load;
    assign if_lo.blank_lz = blz;
    assign if_lo.dp_mask  = dpm;
    assign if_hi.bcd      = bcd;
    assign if_hi.load     = load;
    assign if_hi.blank_lz = blz;
    assign if_hi.dp_mask  = dpm;

    bcd_seg_scanner #(.SCAN_DIV(8), .DIV_WIDTH(4), .ACTIVE_LOW(1'b1)) u_lo (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if_lo.slave)
    );

    bcd_seg_scanner #(.SCAN_DIV(8), .DIV_WIDTH(4), .ACTIVE_LOW(1'b0)) u_hi (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if_hi.slave)
    );

    typedef struct {
        logic [15:0] bcd;
        logic        blz;
        logic [3:0]  dpm;
        int          dig;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        err;
    } vec_t;

    vec_t vt [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Active-high {an,seg,dp,err} after edge kk (kk=1 is the first edge out of reset)
    function automatic logic [12:0] model(input int kk, input logic [15:0] s,
                                          input logic b, input logic [3:0] m);
        int          d;
        logic [15:0] up;
        logic [3:0]  nib;
        logic [6:0]  sg;
        logic [3:0]  an;
        logic        e;
        e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            up = s >> (4 * i);
            if (up[3:0] > 4'd9) e = 1'b1;
        end
        if (kk % 8 == 0) return {4'b0, 7'b0, 1'b0, e};
        d   = ((kk - 1) / 8) % 4;
        up  = s >> (4 * d);
        nib = up[3:0];
        sg  = (nib > 4'd9) ? 7'h40 : gl[nib];
        if (b && d != 0 && up == 16'h0) sg = 7'h00;
        an  = 4'b0001 << d;
        return {an, sg, m[d], e};
    endfunction

    task automatic step();
        logic [15:0] used, b_in;
        logic        ld, bl;
        logic [3:0]  m;
        logic [12:0] eh;
        used = snap_m;
        b_in = bcd;
        ld   = load;
        bl   = blz;
        m    = dpm;
        @(posedge clk);
        #1;
        k++;
        if (ld) snap_m = b_in;
        eh = model(k, used, bl, m);
        chk("out_hi", 32'({if_hi.an, if_hi.seg, if_hi.dp, if_hi.err}), 32'(eh));
        chk("out_lo", 32'({if_lo.an, if_lo.seg, if_lo.dp, if_lo.err}),
            32'({~eh[12:1], eh[0]}));
    endtask

    task automatic do_load(input logic [15:0] v);
        bcd  = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_slot(input int d);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(k % 8 != 0 && ((k - 1) / 8) % 4 == d) && n < 64);
        if (n >= 64) chk("slot_timeout", 32'(n), 32'(0));
    endtask

    initial begin
        int dead;
        gl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

        vt.push_back('{16'h1234, 1'b0, 4'h0, 0, 4'b1110, 7'b0011001, 1'b1, 1'b0});
        vt.push_back('{16'h1234, 1'b0, 4'h0, 1, 4'b1101, 7'b0110000, 1'b1, 1'b0});
        vt.push_back('{16'h1234, 1'b0, 4'h0, 2, 4'b1011, 7'b0100100, 1'b1, 1'b0});
        vt.push_back('{16'h1234, 1'b0, 4'h0, 3, 4'b0111, 7'b1111001, 1'b1, 1'b0});
        vt.push_back('{16'h0050, 1'b1, 4'h0, 3, 4'b0111, 7'b1111111, 1'b1, 1'b0});
        vt.push_back('{16'h0050, 1'b1, 4'h0, 2, 4'b1011, 7'b1111111, 1'b1, 1'b0});
        vt.push_back('{16'h0050, 1'b1, 4'h0, 1, 4'b1101, 7'b0010010, 1'b1, 1'b0});
        vt.push_back('{16'h0050, 1'b1, 4'h0, 0, 4'b1110, 7'b1000000, 1'b1, 1'b0});
        vt.push_back('{16'h0050, 1'b0, 4'h0, 3, 4'b0111, 7'b1000000, 1'b1, 1'b0});
        vt.push_back('{16'h0050, 1'b0, 4'h0, 2, 4'b1011, 7'b1000000, 1'b1, 1'b0});
        vt.push_back('{16'h00A7, 1'b1, 4'h2, 1, 4'b1101, 7'b0111111, 1'b0, 1'b1});
        vt.push_back('{16'h00A7, 1'b1, 4'h2, 2, 4'b1011, 7'b1111111, 1'b1, 1'b1});
        vt.push_back('{16'h00A7, 1'b1, 4'h2, 0, 4'b1110, 7'b1111000, 1'b1, 1'b1});
        vt.push_back('{16'h00A7, 1'b0, 4'h2, 3, 4'b0111, 7'b1000000, 1'b1, 1'b1});
        vt.push_back('{16'h0007, 1'b1, 4'h0, 0, 4'b1110, 7'b1111000, 1'b1, 1'b0});
        vt.push_back('{16'h0007, 1'b1, 4'h0, 1, 4'b1101, 7'b1111111, 1'b1, 1'b0});

        #12;
        chk("rst_lo", 32'({if_lo.an, if_lo.seg, if_lo.dp, if_lo.err}), 32'(13'h1FFE));
        chk("rst_hi", 32'({if_hi.an, if_hi.seg, if_hi.dp, if_hi.err}), 32'(13'h0000));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        step();
        chk("first_dig0", 32'({if_lo.an, if_lo.seg}), 32'({4'b1110, 7'b1000000}));
        blz = 1'b1;
        repeat (32) step();
        blz = 1'b0;

        foreach (vt[i]) begin
            blz = vt[i].blz;
            dpm = vt[i].dpm;
            if (snap_m !== vt[i].bcd) do_load(vt[i].bcd);
            wait_slot(vt[i].dig);
            chk($sformatf("vec%0d", i),
                32'({if_lo.an, if_lo.seg, if_lo.dp, if_lo.err}),
                32'({vt[i].an, vt[i].seg, vt[i].dp, vt[i].err}));
        end
        dpm = 4'h0;
        blz = 1'b0;

        dead = 0;
        repeat (32) begin
            step();
            if (if_lo.an == 4'hF) dead++;
        end
        chk("dead_cnt", 32'(dead), 32'(4));

        do_load(16'h0000);
        step();
        bcd  = 16'h00A7;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("err_lat0", 32'(if_lo.err), 32'(0));
        step();
        chk("err_lat1", 32'(if_lo.err), 32'(1));
        do_load(16'h0007);
        step();
        chk("err_clear", 32'(if_lo.err), 32'(0));

        while ((k + 1) % 8 != 0) step();
        do_load(16'h8888);
        chk("wrap_dead", 32'(if_lo.an), 32'(4'hF));
        step();
        chk("wrap_load", 32'(if_lo.seg), 32'(7'b0000000));

        do_load(16'h9999);
        repeat (32) begin
            step();
            if (k % 8 != 0) begin
                chk("hi_9", 32'(if_hi.seg), 32'(7'b1101111));
                chk("hi_onehot", 32'($onehot(if_hi.an)), 32'(1));
            end
        end

        load = 1'b1;
        repeat (20) begin
            bcd = 16'($urandom);
            step();
        end
        load = 1'b0;

        repeat (400) begin
            if ($urandom % 5 == 0) begin
                bcd = 16'($urandom);
            end else begin
                bcd = '0;
                for (int j = 0; j < 4; j++)
                    if ($urandom % 3 != 0) bcd[4*j +: 4] = 4'($urandom_range(0, 9));
            end
            load = ($urandom % 4 == 0);
            if ($urandom % 8 == 0) blz = 1'($urandom);
            if ($urandom % 8 == 0) dpm = 4'($urandom);
            step();
        end
        load = 1'b0;

        do_load(16'h00A7);
        repeat (3) step();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_lo", 32'({if_lo.an, if_lo.seg, if_lo.dp, if_lo.err}), 32'(13'h1FFE));
        chk("mid_rst_hi", 32'({if_hi.an, if_hi.seg, if_hi.dp, if_hi.err}), 32'(13'h0000));
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        k      = 0;
        snap_m = '0;
        blz    = 1'b1;
        dpm    = 4'h0;
        step();
        chk("restart_dig0", 32'({if_lo.an, if_lo.seg, if_lo.err}),
            32'({4'b1110, 7'b1000000, 1'b0}));
        repeat (32) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
